pe_mac_fxp: RTL and testbench

//  Signed fixed-point systolic MAC processing element: next-generation RSA PE, one per array node.

---
 rtl/pe_mac_fxp_pkg.sv | 23 ++
 rtl/pe_mac_fxp_if.sv | 52 +++++
 rtl/pe_mac_fxp_round_sat.sv | 49 ++++
 rtl/pe_mac_fxp.sv | 200 ++++++++++++++++++++
 tb/tb_pe_mac_fxp.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_mac_fxp_pkg.sv
// pe_mac_fxp_pkg
//   Shared definitions for the fixed-point systolic MAC processing element:
//   default widths, PE_mode direction encodings and the accumulator FSM states.
//   Optional feature macro used by the design: PE_MAC_SAT_EN (see pe_mac_fxp_round_sat).

package pe_mac_fxp_pkg;

  localparam int RSA_DW_DEF = 16;
  localparam int FRAC_W_DEF = 8;
  localparam int ACC_W_DEF  = 40;

  // PE_mode[1] selects the vertical flow, PE_mode[0] the horizontal flow.
  localparam logic N_2_S = 1'b0;
  localparam logic S_2_N = 1'b1;
  localparam logic W_2_E = 1'b0;
  localparam logic E_2_W = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pe_state_e;

endpackage

// File: rtl/pe_mac_fxp_if.sv
// pe_mac_fxp_if
//   Neighbour links of one PE: mode, operand inputs from N/S/W/E, forwarded
//   operand outputs, the result chain in both directions, busy and err.
//   slave  : the PE side (consumes *_i and PE_mode, drives *_o, busy, err)
//   master : the fabric / driver side (the mirror image)

interface pe_mac_fxp_if #(
  parameter int RSA_DW = 16
);

  logic [1:0]        PE_mode;

  logic              cal_en_N_i,   cal_en_S_i;
  logic              cal_done_N_i, cal_done_S_i;
  logic [RSA_DW-1:0] v_data_N_i,   v_data_S_i;
  logic [RSA_DW-1:0] h_data_W_i,   h_data_E_i;
  logic              mulres_val_W_i, mulres_val_E_i;
  logic [RSA_DW-1:0] mulres_W_i,     mulres_E_i;

  logic              cal_en_N_o,   cal_en_S_o;
  logic              cal_done_N_o, cal_done_S_o;
  logic [RSA_DW-1:0] v_data_N_o,   v_data_S_o;
  logic [RSA_DW-1:0] h_data_W_o,   h_data_E_o;
  logic              mulres_val_W_o, mulres_val_E_o;
  logic [RSA_DW-1:0] mulres_W_o,     mulres_E_o;

  logic              busy;
  logic              err;

  modport slave (
    input  PE_mode,
    input  cal_en_N_i, cal_en_S_i, cal_done_N_i, cal_done_S_i,
    input  v_data_N_i, v_data_S_i, h_data_W_i, h_data_E_i,
    input  mulres_val_W_i, mulres_val_E_i, mulres_W_i, mulres_E_i,
    output cal_en_N_o, cal_en_S_o, cal_done_N_o, cal_done_S_o,
    output v_data_N_o, v_data_S_o, h_data_W_o, h_data_E_o,
    output mulres_val_W_o, mulres_val_E_o, mulres_W_o, mulres_E_o,
    output busy, err
  );

  modport master (
    output PE_mode,
    output cal_en_N_i, cal_en_S_i, cal_done_N_i, cal_done_S_i,
    output v_data_N_i, v_data_S_i, h_data_W_i, h_data_E_i,
    output mulres_val_W_i, mulres_val_E_i, mulres_W_i, mulres_E_i,
    input  cal_en_N_o, cal_en_S_o, cal_done_N_o, cal_done_S_o,
    input  v_data_N_o, v_data_S_o, h_data_W_o, h_data_E_o,
    input  mulres_val_W_o, mulres_val_E_o, mulres_W_o, mulres_E_o,
    input  busy, err
  );

endinterface

// File: rtl/pe_mac_fxp_round_sat.sv
// pe_mac_fxp_round_sat
//   Combinational conversion of the ACC_W-bit accumulator sum to an RSA_DW
//   Q-format result: round half-up at bit FRAC_W-1, arithmetic shift by FRAC_W,
//   then narrow.
//   Macro PE_MAC_SAT_EN: defined -> narrowing saturates to the signed RSA_DW
//   range; undefined -> narrowing keeps the low RSA_DW bits (wraps).
// Ports
//   sum_i  in   ACC_W   signed accumulator sum
//   res_o  out  RSA_DW  rounded, narrowed result

module pe_mac_fxp_round_sat #(
  parameter int RSA_DW = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic signed [ACC_W-1:0] sum_i,
  output logic        [RSA_DW-1:0] res_o
);

  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_W-1);

  // One extra bit so the rounding increment can never wrap the sum.
  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  assign biased  = $signed({sum_i[ACC_W-1], sum_i}) + $signed(HALF);
  assign shifted = biased >>> FRAC_W;

`ifdef PE_MAC_SAT_EN
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-RSA_DW){1'b0}}, {(RSA_DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W+2-RSA_DW){1'b1}}, {(RSA_DW-1){1'b0}}};

  always_comb begin
    if (shifted > MAX_V) begin
      res_o = MAX_V[RSA_DW-1:0];
    end else if (shifted < MIN_V) begin
      res_o = MIN_V[RSA_DW-1:0];
    end else begin
      res_o = shifted[RSA_DW-1:0];
    end
  end
`else
  // Wrapping narrow: the bits above RSA_DW are deliberately discarded.
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_W:RSA_DW];
  assign res_o     = shifted[RSA_DW-1:0];
`endif

endmodule

// File: rtl/pe_mac_fxp.sv
// pe_mac_fxp
//   Signed fixed-point systolic MAC processing element. Forwards the vertical
//   operand N<->S and the horizontal operand W<->E, accumulates h*v through a
//   2-stage pipeline into an ACC_W accumulator and emits a rounded RSA_DW
//   result on the mulres chain, which flows opposite to the h direction.
//   A 1-entry buffer absorbs an incoming chain result that collides with a
//   local result. Optional macro PE_MAC_SAT_EN selects saturating narrowing.
// Ports
//   clk      in  rising-edge clock
//   sys_rst  in  synchronous active-high reset
//   pe       pe_mac_fxp_if.slave: PE_mode, operand in/out links, mulres chain
//            in/out links, busy (accumulating or result pending), err (sticky
//            buffer overrun)
//
//   state | meaning
//   IDLE  | no dot product open; next product starts from zero
//   ACC   | dot product open; products add onto acc

module pe_mac_fxp
  import pe_mac_fxp_pkg::*;
#(
  parameter int RSA_DW = RSA_DW_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic        clk,
  input  logic        sys_rst,
  pe_mac_fxp_if.slave pe
);

  localparam int PW = 2 * RSA_DW;

  logic [1:0]               mode_q;
  logic                     mode_chg;
  logic                     cal_en, cal_done;
  logic signed [RSA_DW-1:0] v_in, h_in;
  logic                     mr_val_in;
  logic        [RSA_DW-1:0] mr_in;

  logic                     fwd_en_q, fwd_en_d, fwd_done_q, fwd_done_d;
  logic        [RSA_DW-1:0] fwd_v_q, fwd_v_d, fwd_h_q, fwd_h_d;
  logic signed [PW-1:0]     prod_q, prod_d;
  logic                     prod_val_q, prod_val_d, last_q, last_d;
  pe_state_e                state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, prod_ext, acc_base, sum;
  logic                     local_val;
  logic        [RSA_DW-1:0] rounded;
  logic                     buf_vld;
  logic        [RSA_DW-1:0] buf_q, buf_d, mr_q, mr_d;
  logic                     buf_full_q, buf_full_d, mr_val_q, mr_val_d, err_q, err_d;

  // Input selection follows the current mode.
  assign mode_chg  = (pe.PE_mode != mode_q);
  assign cal_en    = (pe.PE_mode[1] == S_2_N) ? pe.cal_en_S_i   : pe.cal_en_N_i;
  assign cal_done  = (pe.PE_mode[1] == S_2_N) ? pe.cal_done_S_i : pe.cal_done_N_i;
  assign v_in      = (pe.PE_mode[1] == S_2_N) ? pe.v_data_S_i   : pe.v_data_N_i;
  assign h_in      = (pe.PE_mode[0] == E_2_W) ? pe.h_data_E_i   : pe.h_data_W_i;
  assign mr_val_in = (pe.PE_mode[0] == E_2_W) ? pe.mulres_val_W_i : pe.mulres_val_E_i;
  assign mr_in     = (pe.PE_mode[0] == E_2_W) ? pe.mulres_W_i     : pe.mulres_E_i;

  // Forwarding and stage 1 (product).
  always_comb begin
    fwd_en_d   = cal_en;
    fwd_done_d = cal_done;
    fwd_v_d    = cal_en ? v_in : '0;
    fwd_h_d    = cal_en ? h_in : '0;
    prod_d     = prod_q;
    prod_val_d = cal_en;
    last_d     = cal_en & cal_done;
    if (cal_en) begin
      prod_d = PW'(v_in) * PW'(h_in);
    end
    if (mode_chg) begin
      prod_d     = '0;
      prod_val_d = 1'b0;
      last_d     = 1'b0;
    end
  end

  // Stage 2 (accumulate) and FSM.
  assign prod_ext = ACC_W'(prod_q);
  assign acc_base = (state_q == IDLE) ? '0 : acc_q;
  assign sum      = acc_base + prod_ext;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    local_val = 1'b0;
    if (mode_chg) begin
      state_d = IDLE;
      acc_d   = '0;
    end else if (prod_val_q) begin
      acc_d     = sum;
      local_val = last_q;
      // A last product closes the dot product from either state.
      state_d   = last_q ? IDLE : ACC;
    end
  end

  pe_mac_fxp_round_sat #(
    .RSA_DW (RSA_DW),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_round_sat (
    .sum_i (sum),
    .res_o (rounded)
  );

  // Result chain: local > buffer > incoming. A mode change discards the buffer.
  assign buf_vld = buf_full_q & ~mode_chg;

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    err_d      = err_q;
    mr_val_d   = 1'b0;
    mr_d       = '0;
    if (local_val) begin
      mr_val_d = 1'b1;
      mr_d     = rounded;
      if (mr_val_in) begin
        if (buf_vld) begin
          err_d = 1'b1;
        end else begin
          buf_d      = mr_in;
          buf_full_d = 1'b1;
        end
      end
    end else if (buf_vld) begin
      mr_val_d = 1'b1;
      mr_d     = buf_q;
      if (mr_val_in) begin
        buf_d = mr_in;
      end else begin
        buf_full_d = 1'b0;
      end
    end else if (mr_val_in) begin
      mr_val_d = 1'b1;
      mr_d     = mr_in;
    end
    if (mode_chg) begin
      buf_d      = '0;
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      mode_q     <= 2'b00;
      fwd_en_q   <= 1'b0;
      fwd_done_q <= 1'b0;
      fwd_v_q    <= '0;
      fwd_h_q    <= '0;
      prod_q     <= '0;
      prod_val_q <= 1'b0;
      last_q     <= 1'b0;
      state_q    <= IDLE;
      acc_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      mr_q       <= '0;
      mr_val_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mode_q     <= pe.PE_mode;
      fwd_en_q   <= fwd_en_d;
      fwd_done_q <= fwd_done_d;
      fwd_v_q    <= fwd_v_d;
      fwd_h_q    <= fwd_h_d;
      prod_q     <= prod_d;
      prod_val_q <= prod_val_d;
      last_q     <= last_d;
      state_q    <= state_d;
      acc_q      <= acc_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      mr_q       <= mr_d;
      mr_val_q   <= mr_val_d;
      err_q      <= err_d;
    end
  end

  // Outputs are steered by the mode that was live when they were captured.
  assign pe.cal_en_S_o     = (mode_q[1] == N_2_S) & fwd_en_q;
  assign pe.cal_done_S_o   = (mode_q[1] == N_2_S) & fwd_done_q;
  assign pe.v_data_S_o     = (mode_q[1] == N_2_S) ? fwd_v_q : '0;
  assign pe.cal_en_N_o     = (mode_q[1] == S_2_N) & fwd_en_q;
  assign pe.cal_done_N_o   = (mode_q[1] == S_2_N) & fwd_done_q;
  assign pe.v_data_N_o     = (mode_q[1] == S_2_N) ? fwd_v_q : '0;
  assign pe.h_data_E_o     = (mode_q[0] == W_2_E) ? fwd_h_q : '0;
  assign pe.h_data_W_o     = (mode_q[0] == E_2_W) ? fwd_h_q : '0;
  assign pe.mulres_val_W_o = (mode_q[0] == W_2_E) & mr_val_q;
  assign pe.mulres_W_o     = (mode_q[0] == W_2_E) ? mr_q : '0;
  assign pe.mulres_val_E_o = (mode_q[0] == E_2_W) & mr_val_q;
  assign pe.mulres_E_o     = (mode_q[0] == E_2_W) ? mr_q : '0;

  assign pe.busy = (state_q == ACC) | prod_val_q | buf_full_q;
  assign pe.err  = err_q;

endmodule

// File: tb/tb_pe_mac_fxp.sv
// tb_pe_mac_fxp
//   Self-checking bench for pe_mac_fxp. Dot-product results are predicted from
//   plain integer arithmetic over the driven operand list; chain behaviour is
//   predicted from the priority rules scenario by scenario.
//   Honours PE_MAC_SAT_EN in the reference model.

module tb_pe_mac_fxp;

  localparam int DW = 16;
  localparam int FW = 8;
  localparam int AW = 40;

  logic clk = 1'b0;
  logic sys_rst;

  always #5 clk = ~clk;

  pe_mac_fxp_if #(.RSA_DW(DW)) pif ();

  pe_mac_fxp #(
    .RSA_DW (DW),
    .FRAC_W (FW),
    .ACC_W  (AW)
  ) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .pe      (pif)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [1:0]  cur_mode = 2'b00;
  logic [15:0] th [0:15];
  logic [15:0] tv [0:15];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact sum, 40-bit wrap, round half-up, shift, narrow.
  function automatic logic [15:0] ref_dot(input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s += longint'($signed(th[i])) * longint'($signed(tv[i]));
    end
    s = (s <<< (64 - AW)) >>> (64 - AW);
    s = (s + (64'sd1 <<< (FW - 1))) >>> FW;
`ifdef PE_MAC_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  // Selected side gets the real values, the other side gets junk.
  task automatic drive_term(input logic [15:0] h, input logic [15:0] v, input logic en, input logic done);
    if (cur_mode[1]) begin
      pif.cal_en_S_i = en;  pif.cal_done_S_i = done;  pif.v_data_S_i = v;
      pif.cal_en_N_i = 1'($urandom); pif.cal_done_N_i = 1'($urandom); pif.v_data_N_i = 16'($urandom);
    end else begin
      pif.cal_en_N_i = en;  pif.cal_done_N_i = done;  pif.v_data_N_i = v;
      pif.cal_en_S_i = 1'($urandom); pif.cal_done_S_i = 1'($urandom); pif.v_data_S_i = 16'($urandom);
    end
    if (cur_mode[0]) begin
      pif.h_data_E_i = h; pif.h_data_W_i = 16'($urandom);
    end else begin
      pif.h_data_W_i = h; pif.h_data_E_i = 16'($urandom);
    end
  endtask

  task automatic drive_mr(input logic val, input logic [15:0] d);
    if (cur_mode[0]) begin
      pif.mulres_val_W_i = val; pif.mulres_W_i = d;
      pif.mulres_val_E_i = 1'($urandom); pif.mulres_E_i = 16'($urandom);
    end else begin
      pif.mulres_val_E_i = val; pif.mulres_E_i = d;
      pif.mulres_val_W_i = 1'($urandom); pif.mulres_W_i = 16'($urandom);
    end
  endtask

  task automatic idle_in;
    drive_term(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    drive_mr(1'b0, 16'($urandom));
  endtask

  task automatic set_mode(input logic [1:0] m);
    pif.PE_mode = m;
    cur_mode    = m;
    idle_in();
    tick();
    tick();
  endtask

  task automatic chk_fwd(input string tag, input logic [15:0] h, input logic [15:0] v, input logic en, input logic done);
    logic [35:0] vexp;
    logic [31:0] hexp;
    vexp = cur_mode[1] ? {en, done, v, 18'd0} : {18'd0, en, done, v};
    hexp = cur_mode[0] ? {h, 16'd0} : {16'd0, h};
    chk({tag, "_vfwd"}, 128'({pif.cal_en_N_o, pif.cal_done_N_o, pif.v_data_N_o,
                              pif.cal_en_S_o, pif.cal_done_S_o, pif.v_data_S_o}), 128'(vexp));
    chk({tag, "_hfwd"}, 128'({pif.h_data_W_o, pif.h_data_E_o}), 128'(hexp));
  endtask

  task automatic chk_res(input string tag, input logic val, input logic [15:0] d);
    logic [33:0] e;
    e = cur_mode[0] ? {17'd0, val, d} : {val, d, 17'd0};
    chk(tag, 128'({pif.mulres_val_W_o, pif.mulres_W_o, pif.mulres_val_E_o, pif.mulres_E_o}), 128'(e));
  endtask

  function automatic logic [103:0] all_out;
    return {pif.cal_en_N_o, pif.cal_en_S_o, pif.cal_done_N_o, pif.cal_done_S_o,
            pif.v_data_N_o, pif.v_data_S_o, pif.h_data_W_o, pif.h_data_E_o,
            pif.mulres_val_W_o, pif.mulres_val_E_o, pif.mulres_W_o, pif.mulres_E_o,
            pif.busy, pif.err};
  endfunction

  // Feeds th/tv[0..n-1] with done on the last term; result expected at done+2.
  task automatic run_dot(input string tag, input int n, input logic [15:0] exp);
    for (int i = 0; i < n; i++) begin
      drive_term(th[i], tv[i], 1'b1, i == n - 1);
      tick();
      chk_fwd($sformatf("%s_t%0d", tag, i), th[i], tv[i], 1'b1, i == n - 1);
      chk({tag, "_busy"}, 128'(pif.busy), 128'(1));
    end
    idle_in();
    chk_res({tag, "_early"}, 1'b0, 16'h0);
    tick();
    chk_res({tag, "_res"}, 1'b1, exp);
    chk_fwd({tag, "_gate"}, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    chk_res({tag, "_pulse"}, 1'b0, 16'h0);
    chk({tag, "_idle"}, 128'(pif.busy), 128'(0));
  endtask

  logic [15:0] ra, rb, la, lb, exp_sat;
  int          n;

  initial begin
    sys_rst     = 1'b1;
    pif.PE_mode = 2'b00;
    cur_mode    = 2'b00;
    drive_term(16'($urandom), 16'($urandom), 1'b1, 1'b1);
    drive_mr(1'b1, 16'($urandom));
    tick();
    tick();
    chk("reset_outputs", 128'(all_out()), 128'(0));
    sys_rst = 1'b0;
    idle_in();
    tick();

    // Spec stream, mode 00: 1.0*2.0 three times -> 6.0.
    for (int i = 0; i < 3; i++) begin th[i] = 16'h0100; tv[i] = 16'h0200; end
    run_dot("m00_dot3", 3, 16'h0600);

    set_mode(2'b11);
    run_dot("m11_dot3", 3, 16'h0600);

    set_mode(2'b00);
`ifdef PE_MAC_SAT_EN
    exp_sat = 16'h7FFF;
`else
    exp_sat = 16'h0400;
`endif
    for (int i = 0; i < 4; i++) begin th[i] = 16'h7F00; tv[i] = 16'h7F00; end
    run_dot("big_narrow", 4, exp_sat);

    th[0] = 16'h0001; tv[0] = 16'h0080;
    run_dot("round_half", 1, 16'h0001);
    th[0] = 16'h0001; tv[0] = 16'h007F;
    run_dot("round_below", 1, 16'h0000);

    // Local result and incoming 0x1234 in the same cycle.
    th[0] = 16'($urandom); tv[0] = 16'($urandom);
    th[1] = 16'($urandom); tv[1] = 16'($urandom);
    la = ref_dot(2);
    drive_term(th[0], tv[0], 1'b1, 1'b0); tick();
    drive_term(th[1], tv[1], 1'b1, 1'b1); tick();
    idle_in();
    drive_mr(1'b1, 16'h1234);
    tick();
    chk_res("coll_local", 1'b1, la);
    drive_mr(1'b0, 16'h0);
    tick();
    chk_res("coll_buffered", 1'b1, 16'h1234);
    chk("coll_err", 128'(pif.err), 128'(0));
    tick();
    chk_res("coll_drain", 1'b0, 16'h0);

    // Two collisions back to back in mode 01: second incoming is dropped.
    set_mode(2'b01);
    ra = 16'($urandom); rb = 16'($urandom);
    th[0] = 16'($urandom); tv[0] = 16'($urandom); la = ref_dot(1);
    drive_term(th[0], tv[0], 1'b1, 1'b1);
    tick();
    th[0] = 16'($urandom); tv[0] = 16'($urandom); lb = ref_dot(1);
    drive_term(th[0], tv[0], 1'b1, 1'b1);
    drive_mr(1'b1, ra);
    tick();
    chk_res("dbl_l1", 1'b1, la);
    idle_in();
    drive_mr(1'b1, rb);
    tick();
    chk_res("dbl_l2", 1'b1, lb);
    chk("dbl_err", 128'(pif.err), 128'(1));
    chk("dbl_busy", 128'(pif.busy), 128'(1));
    idle_in();
    tick();
    chk_res("dbl_buf", 1'b1, ra);
    tick();
    chk_res("dbl_nodup", 1'b0, 16'h0);
    chk("dbl_idle", 128'(pif.busy), 128'(0));
    tick();
    chk("err_sticky", 128'(pif.err), 128'(1));

    // Pass-through, mode 01.
    ra = 16'($urandom);
    drive_mr(1'b1, ra);
    tick();
    chk_res("pass_thru", 1'b1, ra);
    drive_mr(1'b0, 16'h0);
    tick();
    chk_res("pass_end", 1'b0, 16'h0);

    // Mode change with a result pending: no result emitted.
    set_mode(2'b10);
    th[0] = 16'h0300; tv[0] = 16'h0300;
    drive_term(th[0], tv[0], 1'b1, 1'b1);
    tick();
    pif.PE_mode = 2'b00;
    cur_mode    = 2'b00;
    idle_in();
    tick();
    chk("mchg_nores", 128'({pif.mulres_val_W_o, pif.mulres_W_o, pif.mulres_val_E_o, pif.mulres_E_o}), 128'(0));
    chk("mchg_busy0", 128'(pif.busy), 128'(0));
    tick();

    // Mode change mid-accumulation: open sum is abandoned.
    for (int i = 0; i < 2; i++) begin
      drive_term(16'h0400, 16'h0400, 1'b1, 1'b0);
      tick();
    end
    pif.PE_mode = 2'b01;
    cur_mode    = 2'b01;
    idle_in();
    tick();
    chk("mid_busy0", 128'(pif.busy), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_nores%0d", i), 128'({pif.mulres_val_W_o, pif.mulres_val_E_o}), 128'(0));
    end
    th[0] = 16'($urandom); tv[0] = 16'($urandom);
    run_dot("mid_fresh", 1, ref_dot(1));

    // Randomized dot products across all modes.
    for (int k = 0; k < 24; k++) begin
      logic [1:0] m;
      m = 2'($urandom);
      if (m != cur_mode) set_mode(m);
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(1, 0) == 1) begin
          th[i] = 16'($urandom); tv[i] = 16'($urandom);
        end else begin
          th[i] = 16'($urandom_range(1023, 0) - 512);
          tv[i] = 16'($urandom_range(1023, 0) - 512);
        end
      end
      run_dot($sformatf("rnd%0d", k), n, ref_dot(n));
    end

    chk("err_still", 128'(pif.err), 128'(1));

    // sys_rst in the middle of activity.
    drive_term(16'h1111, 16'h2222, 1'b1, 1'b0);
    drive_mr(1'b1, 16'h5555);
    tick();
    sys_rst = 1'b1;
    tick();
    chk("midrst_outputs", 128'(all_out()), 128'(0));
    sys_rst = 1'b0;
    idle_in();
    tick();
    tick();
    chk("post_rst_err", 128'(pif.err), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
